// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - run/step/halt sequencer for an external up/down event counter
module count_sequencer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_p,
    input  logic             stop_p,
    input  logic             step_p,
    input  logic             clr_p,
    input  logic             dir,
    input  logic             wrap,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] count_in,
    output logic             inc_o,
    output logic             dec_o,
    output logic             clr_o,
    output logic             running,
    output logic             done,
    output logic             at_limit
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          inc_q, inc_d;
    logic          dec_q, dec_d;
    logic          clr_q, clr_d;
    logic          running_q, running_d;
    logic          done_q, done_d;

    logic tick;
    logic move_inc;
    logic move_dec;
    logic move_clr;
    logic move_stall;

    // Terminal value depends on direction: limit going up, zero going down.
    assign at_limit = dir ? (count_in == limit) : (count_in == '0);

    assign tick = (state_q == RUN) && (presc_q == PS_LAST);

    // What a single move would do given the current count, direction and wrap mode.
    always_comb begin
        move_inc   = dir && !at_limit;
        move_clr   = dir && at_limit && wrap;
        move_dec   = !dir && (!at_limit || wrap);
        move_stall = at_limit && !wrap;
    end

    // Next-state, prescaler and strobe decisions; clear outranks every other command.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        clr_d   = 1'b0;
        done_d  = 1'b0;

        if (clr_p) begin
            clr_d   = 1'b1;
            state_d = IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_p) begin
                        state_d = RUN;
                        presc_d = '0;
                    end else if (step_p) begin
                        // A stalled step in IDLE is silent: no strobe and no done.
                        inc_d = move_inc;
                        dec_d = move_dec;
                        clr_d = move_clr;
                    end
                end
                RUN: begin
                    if (stop_p) begin
                        state_d = IDLE;
                        presc_d = '0;
                    end else if (tick) begin
                        presc_d = '0;
                        if (move_stall) begin
                            state_d = HALT;
                            done_d  = 1'b1;
                        end else begin
                            inc_d = move_inc;
                            dec_d = move_dec;
                            clr_d = move_clr;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                HALT: begin
                    if (stop_p) begin
                        state_d = IDLE;
                        presc_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    presc_d = '0;
                end
            endcase
        end

        running_d = (state_d == RUN);
    end

    // State, prescaler and registered outputs; reset drops any strobe in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            clr_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
            clr_q     <= clr_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign inc_o   = inc_q;
    assign dec_o   = dec_q;
    assign clr_o   = clr_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - scoreboard bench for count_sequencer with PRESCALE=4
module tb_count_sequencer;

    localparam int W = 4;
    localparam int P = 4;

    localparam int K_INC  = 0;
    localparam int K_DEC  = 1;
    localparam int K_CLR  = 2;
    localparam int K_DONE = 3;

    typedef struct {
        int cyc;
        int kind;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_p = 1'b0;
    logic         stop_p = 1'b0;
    logic         step_p = 1'b0;
    logic         clr_p = 1'b0;
    logic         dir = 1'b1;
    logic         wrap = 1'b0;
    logic [W-1:0] limit = 4'd9;
    logic [W-1:0] count_in = '0;
    logic         inc_o, dec_o, clr_o, running, done, at_limit;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];

    count_sequencer #(.WIDTH(W), .PRESCALE(P)) dut (
        .clk(clk), .rst(rst),
        .start_p(start_p), .stop_p(stop_p), .step_p(step_p), .clr_p(clr_p),
        .dir(dir), .wrap(wrap), .limit(limit), .count_in(count_in),
        .inc_o(inc_o), .dec_o(dec_o), .clr_o(clr_o),
        .running(running), .done(done), .at_limit(at_limit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External counter that the sequencer drives.
    always @(posedge clk) begin
        if (inc_o)      count_in <= count_in + 4'd1;
        else if (dec_o) count_in <= count_in - 4'd1;
        else if (clr_o) count_in <= '0;
    end

    // Monitor: every strobe/done cycle must match the head of the expectation queue.
    always @(negedge clk) begin
        int got;
        int nset;
        exp_t e;
        nset = int'(inc_o) + int'(dec_o) + int'(clr_o) + int'(done);
        if (nset != 0) begin
            got = inc_o ? K_INC : dec_o ? K_DEC : clr_o ? K_CLR : K_DONE;
            checks++;
            if (nset > 1) begin
                errors++;
                $display("FAIL onehot cyc=%0d got %0d outputs high, required 1", cyc, nset);
            end
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected cyc=%0d got kind %0d, required none", cyc, got);
            end else begin
                e = expq.pop_front();
                if (e.kind != got || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL event got kind %0d at cyc %0d, required kind %0d at cyc %0d",
                             got, cyc, e.kind, e.cyc);
                end
            end
        end
    end

    function automatic void push(input int c, input int k);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        expq.push_back(e);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d, required %0d", name, cyc, act, req);
        end
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drive(input int c, input logic st, input logic sp, input logic sk, input logic cl);
        at_cycle(c);
        start_p = st;
        stop_p  = sp;
        step_p  = sk;
        clr_p   = cl;
        @(negedge clk);
        start_p = 1'b0;
        stop_p  = 1'b0;
        step_p  = 1'b0;
        clr_p   = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (6) @(negedge clk);
        #1;
        chk(name, expq.size(), 0);
    endtask

    initial begin
        int c0;
        #1;
        chk("rst_running", running, 0);
        chk("rst_strobes", int'(inc_o) + int'(dec_o) + int'(clr_o) + int'(done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_running", running, 0);

        // Auto up to limit 9 with halt.
        dir = 1'b1; wrap = 1'b0; limit = 4'd9;
        c0 = cyc + 2;
        for (int k = 0; k < 9; k++) push(c0 + P + 1 + P * k, K_INC);
        push(c0 + P + 1 + P * 9, K_DONE);
        drive(c0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("run_start", running, 1);
        at_cycle(c0 + 40);
        chk("run_before_halt", running, 1);
        at_cycle(c0 + 41);
        chk("halt_running", running, 0);
        chk("halt_at_limit", at_limit, 1);
        chk("halt_count", count_in, 9);
        drive(c0 + 44, 1'b1, 1'b0, 1'b0, 1'b0);
        at_cycle(c0 + 55);
        chk("halt_ignores_start", running, 0);
        drain("drain_halt");
        drive(cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Auto up with wrap at 9, then stop on a tick cycle.
        push(cyc + 2, K_CLR);
        drive(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b1);
        wrap = 1'b1;
        c0 = cyc + 2;
        for (int k = 0; k < 12; k++) push(c0 + P + 1 + P * k, (k == 9) ? K_CLR : K_INC);
        drive(c0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(c0 + 52, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("stop_on_tick_running", running, 0);
        drain("drain_wrap");
        chk("wrap_count", count_in, 2);

        // Single steps in IDLE.
        wrap = 1'b0; limit = 4'd15; dir = 1'b1;
        #1;
        chk("at_limit_low", at_limit, 0);
        push(cyc + 2, K_INC);
        drive(cyc + 1, 1'b0, 1'b0, 1'b1, 1'b0);
        push(cyc + 2, K_CLR);
        drive(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b1);
        dir = 1'b0; wrap = 1'b1;
        @(negedge clk);
        #1;
        chk("at_limit_down_zero", at_limit, 1);
        push(cyc + 2, K_DEC);
        drive(cyc + 1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("down_wrap_count", count_in, 15);
        push(cyc + 2, K_CLR);
        drive(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b1);
        wrap = 1'b0;
        @(negedge clk);
        drive(cyc + 1, 1'b0, 1'b0, 1'b1, 1'b0);
        drain("drain_step");
        chk("down_stall_count", count_in, 0);

        // Step during RUN must not add a strobe or shift the ticks.
        dir = 1'b1;
        c0 = cyc + 2;
        push(c0 + 5, K_INC);
        push(c0 + 9, K_INC);
        push(c0 + 13, K_INC);
        drive(c0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(c0 + 6, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(c0 + 14, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("stop_running", running, 0);
        drain("drain_run_step");

        // clr+stop+start together while running.
        c0 = cyc + 2;
        push(c0 + 5, K_INC);
        push(c0 + 7, K_CLR);
        drive(c0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(c0 + 6, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("collide_running", running, 0);
        at_cycle(c0 + 20);
        chk("collide_idle", running, 0);
        drain("drain_collide");

        // Asynchronous reset on a tick cycle drops the pending strobe.
        c0 = cyc + 2;
        drive(c0, 1'b1, 1'b0, 1'b0, 1'b0);
        at_cycle(c0 + 4);
        chk("pre_rst_running", running, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_running", running, 0);
        chk("mid_rst_strobes", int'(inc_o) + int'(dec_o) + int'(clr_o) + int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("after_rst_running", running, 0);
        drain("drain_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
